// File: rtl/key_frame_tx.sv
// Serializes one key code into an 11-bit frame (start, 8 data LSB first, odd parity, stop),
// stepping one bit per falling edge of the returned key clock, with a stall timeout.
module key_frame_tx #(
  parameter int TIMEOUT = 10000,
  parameter int TO_W    = 14
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       iKeyClk,
  output logic       oEnable,
  output logic       oKeyData,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [9:0]      frame_q, frame_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [TO_W-1:0] tocnt_q, tocnt_d;
  logic            prev_q;
  logic            enable_q, enable_d;
  logic            keydata_q, keydata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            fall_s;
  logic            timeout_s;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  assign fall_s    = prev_q & ~iKeyClk;
  assign timeout_s = (tocnt_q == TO_LAST);

  // State and output registers
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      frame_q   <= 10'h3FF;
      bitcnt_q  <= 4'd0;
      tocnt_q   <= '0;
      prev_q    <= 1'b1;
      enable_q  <= 1'b0;
      keydata_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bitcnt_q  <= bitcnt_d;
      tocnt_q   <= tocnt_d;
      prev_q    <= iKeyClk;
      enable_q  <= enable_d;
      keydata_q <= keydata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state, frame shifter and counters; the start bit is driven directly,
  // so only {stop, parity, data} is held in the shifter.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    tocnt_d  = tocnt_q;
    case (state_q)
      S_IDLE: begin
        if (iSend) begin
          state_d  = S_SEND;
          frame_d  = {1'b1, odd_parity(iData), iData};
          bitcnt_d = 4'd0;
          tocnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (fall_s) begin
          tocnt_d = '0;
          if (bitcnt_q == 4'd10) begin
            state_d = S_DONE;
          end else begin
            frame_d  = {1'b1, frame_q[9:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          tocnt_d = tocnt_q + TO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    enable_d  = enable_q;
    keydata_d = keydata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iSend) begin
          enable_d  = 1'b1;
          busy_d    = 1'b1;
          keydata_d = 1'b0;
        end else begin
          enable_d  = 1'b0;
          busy_d    = 1'b0;
          keydata_d = 1'b1;
        end
      end
      S_SEND: begin
        if (fall_s) begin
          if (bitcnt_q == 4'd10) begin
            enable_d  = 1'b0;
            keydata_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            keydata_d = frame_q[0];
          end
        end else if (timeout_s) begin
          enable_d  = 1'b0;
          keydata_d = 1'b1;
          err_d     = 1'b1;
        end else begin
          keydata_d = keydata_q;
        end
      end
      S_DONE:  busy_d = 1'b0;
      S_ERROR: busy_d = 1'b0;
      default: begin
        enable_d  = 1'b0;
        keydata_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign oEnable  = enable_q;
  assign oKeyData = keydata_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oErr     = err_q;

endmodule

// File: tb/tb_key_frame_tx.sv
// Directed bench for key_frame_tx: a key-clock model toggling every 50 cycles while
// enabled, and scenario tasks with hand-computed frames (bit i = i-th bit on the line).
module tb_key_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] data;
  logic       kclk;
  logic       en, kd, busy, done, err;

  int   vectors = 0;
  int   miscompares = 0;
  logic fall_bits [0:31];
  int   nfalls;
  int   kcnt;
  bit   force_high;

  key_frame_tx #(.TIMEOUT(200), .TO_W(14)) dut (
    .iClock  (clk),
    .iReset  (rst),
    .iData   (data),
    .iSend   (send),
    .iKeyClk (kclk),
    .oEnable (en),
    .oKeyData(kd),
    .oBusy   (busy),
    .oDone   (done),
    .oErr    (err)
  );

  always #5 clk = ~clk;

  // Key clock generator model; records oKeyData at each falling edge it produces
  initial begin
    kclk = 1'b1;
    kcnt = 0;
    nfalls = 0;
    force_high = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!en) begin
        kclk = 1'b1;
        kcnt = 0;
      end else if (force_high) begin
        kclk = 1'b1;
      end else begin
        kcnt++;
        if (kcnt == 50) begin
          kcnt = 0;
          if (kclk) begin
            if (nfalls < 32) fall_bits[nfalls] = kd;
            nfalls++;
          end
          kclk = ~kclk;
        end
      end
    end
  end

  function automatic logic [10:0] got_frame(input int base);
    logic [10:0] f;
    for (int i = 0; i < 11; i++) f[i] = fall_bits[base + i];
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data = b;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic run_frame(input int budget, output int done_n, output int err_n, output bit fin);
    int cyc;
    done_n = 0;
    err_n = 0;
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) done_n++;
      if (err) err_n++;
      if (!busy) fin = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({en, kd, busy, done, err} !== 5'b01000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 01000", {en, kd, busy, done, err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_1c();
    int dn, en_n;
    bit fin;
    nfalls = 0;
    send_byte(8'h1C);
    vectors++;
    if ({en, busy, kd} !== 3'b110) begin
      miscompares++;
      $display("FAIL accept_1c: got en/busy/kd %b want 110", {en, busy, kd});
    end
    run_frame(3000, dn, en_n, fin);
    vectors++;
    if (!fin || dn !== 1 || en_n !== 0) begin
      miscompares++;
      $display("FAIL done_1c: fin %0d done %0d err %0d want 1 1 0", fin, dn, en_n);
    end
    vectors++;
    if (nfalls !== 11 || got_frame(0) !== 11'h438) begin
      miscompares++;
      $display("FAIL bits_1c: falls %0d frame %h want 11 438", nfalls, got_frame(0));
    end
    vectors++;
    if ({en, kd, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL idle_1c: got en/kd/busy %b want 010", {en, kd, busy});
    end
  endtask

  task automatic test_back_to_back();
    int phase, gap, cyc;
    nfalls = 0;
    phase = 0;
    gap = 0;
    cyc = 0;
    @(negedge clk);
    data = 8'h00;
    send = 1'b1;
    while (phase < 3 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      case (phase)
        0: if (done) begin phase = 1; data = 8'hFF; end
        1: if (!busy) gap++; else begin phase = 2; send = 1'b0; end
        2: if (done) phase = 3;
        default: phase = 3;
      endcase
    end
    send = 1'b0;
    vectors++;
    if (phase !== 3) begin
      miscompares++;
      $display("FAIL b2b_complete: phase %0d want 3", phase);
    end
    vectors++;
    if (gap !== 1) begin
      miscompares++;
      $display("FAIL b2b_gap: busy-low cycles %0d want 1", gap);
    end
    vectors++;
    if (nfalls !== 22 || got_frame(0) !== 11'h600) begin
      miscompares++;
      $display("FAIL b2b_frame00: falls %0d frame %h want 22 600", nfalls, got_frame(0));
    end
    vectors++;
    if (got_frame(11) !== 11'h7FE) begin
      miscompares++;
      $display("FAIL b2b_frameff: frame %h want 7fe", got_frame(11));
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({en, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_no_third: en/busy %b want 00", {en, busy});
    end
  endtask

  task automatic test_timeout();
    int cyc, n, done_seen;
    nfalls = 0;
    force_high = 1'b0;
    send_byte(8'h5A);
    cyc = 0;
    while (nfalls < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (nfalls < 4) begin
      miscompares++;
      $display("FAIL to_reach4: falls %0d want 4", nfalls);
    end
    force_high = 1'b1;
    // n counts edges starting at the one that registers the 4th fall
    n = 0;
    done_seen = 0;
    while (!err && n < 400) begin
      @(posedge clk);
      #2;
      n++;
      if (done) done_seen++;
    end
    vectors++;
    if (n !== 201) begin
      miscompares++;
      $display("FAIL to_latency: err after edge %0d want 201", n);
    end
    vectors++;
    if ({err, en, kd, busy} !== 4'b1011 || done_seen !== 0) begin
      miscompares++;
      $display("FAIL to_outputs: err/en/kd/busy %b done %0d want 1011 0", {err, en, kd, busy}, done_seen);
    end
    @(posedge clk);
    #2;
    vectors++;
    if ({err, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL to_pulse: err/busy/done %b want 000", {err, busy, done});
    end
    force_high = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int dn, en_n, cyc, busy_n;
    bit fin;
    nfalls = 0;
    send_byte(8'hC3);
    cyc = 0;
    while (nfalls < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    data = 8'h12;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    run_frame(3000, dn, en_n, fin);
    vectors++;
    if (!fin || dn !== 1 || en_n !== 0) begin
      miscompares++;
      $display("FAIL ign_done: fin %0d done %0d err %0d want 1 1 0", fin, dn, en_n);
    end
    vectors++;
    if (got_frame(0) !== 11'h786) begin
      miscompares++;
      $display("FAIL ign_bits: frame %h want 786", got_frame(0));
    end
    busy_n = 0;
    repeat (120) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    vectors++;
    if (busy_n !== 0 || nfalls !== 11) begin
      miscompares++;
      $display("FAIL ign_no_second: busy cycles %0d falls %0d want 0 11", busy_n, nfalls);
    end
  endtask

  task automatic test_reset_midframe();
    int dn, en_n, cyc;
    bit fin;
    nfalls = 0;
    send_byte(8'h1C);
    cyc = 0;
    while (nfalls < 6 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({en, kd, busy, done, err} !== 5'b01000) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %b want 01000", {en, kd, busy, done, err});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nfalls = 0;
    send_byte(8'h1C);
    run_frame(3000, dn, en_n, fin);
    vectors++;
    if (!fin || dn !== 1 || en_n !== 0 || nfalls !== 11 || got_frame(0) !== 11'h438) begin
      miscompares++;
      $display("FAIL midreset_resend: fin %0d done %0d err %0d falls %0d frame %h want 1 1 0 11 438",
               fin, dn, en_n, nfalls, got_frame(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    send = 1'b0;
    data = 8'h00;
    test_reset();
    test_frame_1c();
    test_back_to_back();
    test_timeout();
    test_busy_ignore();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
